// File: rtl/digital_lock_ctrl.sv
// Sequential code lock: CODE_LEN-digit entry, compare, try counter, timed alarm lockout, reprogramming.
// Optional build macro ENTRY_TIMEOUT_EN adds an idle timeout (TIMEOUT_CYC) on partial entry/programming.
module digital_lock_ctrl #(
  parameter int DIGIT_W     = 3,
  parameter int CODE_LEN    = 4,
  parameter int MAX_TRIES   = 3,
  parameter int LOCKOUT_CYC = 16,
  parameter logic [DIGIT_W*CODE_LEN-1:0] RESET_CODE = {3'd1, 3'd2, 3'd3, 3'd4}
`ifdef ENTRY_TIMEOUT_EN
  , parameter int TIMEOUT_CYC = 64
`endif
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          digit_vld,
  input  logic [DIGIT_W-1:0]            digit,
  input  logic                          clear,
  input  logic                          lock_cmd,
  input  logic                          prog_en,
  output logic                          unlocked,
  output logic                          alarm,
  output logic                          err,
  output logic                          prog_done,
  output logic [3:0]                    tries_left,
  output logic [$clog2(CODE_LEN):0]     digit_cnt
);

  localparam int CW     = $clog2(CODE_LEN) + 1;
  localparam int CODE_W = DIGIT_W * CODE_LEN;
  localparam int LW     = $clog2(LOCKOUT_CYC);
  localparam logic [CW-1:0] CODE_CNT = CW'(CODE_LEN);
  localparam logic [3:0]    TRY_MAX  = 4'(MAX_TRIES);

  typedef enum logic [2:0] {LOCKED, ENTRY, CHECK, UNLOCKED, PROG, LOCKOUT} state_t;

  state_t              state, state_nxt;
  logic [CODE_W-1:0]   sr, sr_nxt, code, code_nxt, shifted;
  logic [CW-1:0]       cnt_nxt, cnt_inc;
  logic [3:0]          tries_nxt, tries_dec;
  logic [LW-1:0]       lo_cnt, lo_nxt;
  logic                err_nxt, done_nxt, fail, tmo;

  assign shifted   = {sr[CODE_W-DIGIT_W-1:0], digit};
  assign cnt_inc   = digit_cnt + CW'(1);
  assign tries_dec = (tries_left != 4'd0) ? tries_left - 4'd1 : 4'd0;

`ifdef ENTRY_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  logic          collecting;
  assign collecting = (state == ENTRY) || (state == PROG);
  assign tmo = collecting && !digit_vld && (idle_cnt == TW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      idle_cnt <= '0;
    else if (!collecting || digit_vld) idle_cnt <= '0;
    else if (!tmo)                   idle_cnt <= idle_cnt + TW'(1);
  end
`else
  assign tmo = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    sr_nxt    = sr;
    code_nxt  = code;
    cnt_nxt   = digit_cnt;
    tries_nxt = tries_left;
    lo_nxt    = lo_cnt;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    fail      = 1'b0;
    case (state)
      LOCKED: if (digit_vld && !clear) begin
        sr_nxt    = shifted;
        cnt_nxt   = CW'(1);
        state_nxt = (CW'(1) == CODE_CNT) ? CHECK : ENTRY;
      end
      ENTRY: begin
        if (clear) begin
          state_nxt = LOCKED;
          cnt_nxt   = '0;
        end else if (digit_vld) begin
          sr_nxt  = shifted;
          cnt_nxt = cnt_inc;
          if (cnt_inc == CODE_CNT) state_nxt = CHECK;
        end else if (tmo) begin
          fail = 1'b1;
        end
      end
      CHECK: begin
        cnt_nxt = '0;
        if (sr == code) begin
          state_nxt = UNLOCKED;
          tries_nxt = TRY_MAX;
        end else begin
          fail = 1'b1;
        end
      end
      UNLOCKED: begin
        if (lock_cmd) state_nxt = LOCKED;
        else if (prog_en) begin
          state_nxt = PROG;
          cnt_nxt   = '0;
        end
      end
      PROG: begin
        if (lock_cmd || clear) begin
          state_nxt = lock_cmd ? LOCKED : UNLOCKED;
          cnt_nxt   = '0;
        end else if (digit_vld) begin
          sr_nxt = shifted;
          if (cnt_inc == CODE_CNT) begin
            code_nxt  = shifted;
            done_nxt  = 1'b1;
            state_nxt = UNLOCKED;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt = cnt_inc;
          end
        end else if (tmo) begin
          state_nxt = UNLOCKED;
          cnt_nxt   = '0;
        end
      end
      LOCKOUT: begin
        if (lo_cnt == '0) begin
          state_nxt = LOCKED;
          tries_nxt = TRY_MAX;
        end else begin
          lo_nxt = lo_cnt - LW'(1);
        end
      end
      default: state_nxt = LOCKED;
    endcase
    // A failed attempt (bad compare or entry timeout) consumes a try.
    if (fail) begin
      err_nxt   = 1'b1;
      cnt_nxt   = '0;
      tries_nxt = tries_dec;
      state_nxt = (tries_dec == 4'd0) ? LOCKOUT : LOCKED;
      lo_nxt    = LW'(LOCKOUT_CYC - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOCKED;
      sr         <= '0;
      code       <= RESET_CODE;
      digit_cnt  <= '0;
      tries_left <= TRY_MAX;
      lo_cnt     <= '0;
      unlocked   <= 1'b0;
      alarm      <= 1'b0;
      err        <= 1'b0;
      prog_done  <= 1'b0;
    end else begin
      state      <= state_nxt;
      sr         <= sr_nxt;
      code       <= code_nxt;
      digit_cnt  <= cnt_nxt;
      tries_left <= tries_nxt;
      lo_cnt     <= lo_nxt;
      unlocked   <= (state_nxt == UNLOCKED) || (state_nxt == PROG);
      alarm      <= (state_nxt == LOCKOUT);
      err        <= err_nxt;
      prog_done  <= done_nxt;
    end
  end

endmodule
